// File: rtl/ldpc_mem_pkg.sv
// Definitions shared by the LDPC extrinsic-message memory blocks.
// This covers the reader FSM states, buffer sizing and the default RAM geometry.
package ldpc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    localparam int RD_LATENCY     = 1;
    localparam int BUF_DEPTH      = 2;
    localparam int MSG_DATA_WIDTH = 5;
    localparam int MSG_ADDR_WIDTH = 8;

endpackage

// File: rtl/ext_msg_skid_fifo.sv
// Two-entry first-word-fall-through buffer that absorbs the RAM read latency.
// Pointers and occupancy are reset. Storage is not reset, and the output is gated while empty.
module ext_msg_skid_fifo
    import ldpc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = MSG_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  pop_ok;
    logic                  push_ok;

    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign empty    = (count_q == 2'd0);
    assign full     = (count_q == 2'(BUF_DEPTH));
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ext_msg_reader.sv
// Read-side sequencer for the extrinsic-message RAM.
// It streams num_msgs consecutive words from base_addr as a valid/ready stream.
module ext_msg_reader
    import ldpc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = MSG_DATA_WIDTH,
    parameter int ADDR_WIDTH = MSG_ADDR_WIDTH,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_msgs,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_cs,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    rd_state_e             state;
    rd_state_e             next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  issue_rem;
    logic [LEN_WIDTH-1:0]  accept_rem;
    logic                  rd_vld_p1;
    logic [1:0]            fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            occ_after;
    logic                  pop;
    logic                  issue;

    assign pop = m_valid & m_ready;

    // Credit counts the slot freed by this cycle's pop, which keeps one read per cycle
    // under a ready sink while buffer plus in-flight never exceeds the buffer depth.
    assign occ_after = fifo_count + {1'b0, rd_vld_p1} - {1'b0, pop};
    assign issue     = (state == READ) && (occ_after < 2'(BUF_DEPTH)) && !(fifo_full && !pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (num_msgs == '0) ? DONE : READ;
            READ:    if (issue && issue_rem == LEN_WIDTH'(1)) next_state = DRAIN;
            DRAIN:   if (pop && accept_rem == LEN_WIDTH'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == READ) || (state == DRAIN);
        done        = (state == DONE);
        ram_cs      = issue;
        ram_we      = 1'b0;
        ram_address = issue ? addr_q : '0;
        m_last      = m_valid && (accept_rem == LEN_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            issue_rem  <= '0;
            accept_rem <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                addr_q     <= base_addr;
                issue_rem  <= num_msgs;
                accept_rem <= num_msgs;
            end
        end else begin
            if (issue) begin
                addr_q    <= addr_q + ADDR_WIDTH'(1);
                issue_rem <= issue_rem - LEN_WIDTH'(1);
            end
            if (pop && accept_rem != '0) accept_rem <= accept_rem - LEN_WIDTH'(1);
        end
    end

    // Stage p1: read issued last cycle, RAM data present this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_vld_p1 <= 1'b0;
        else        rd_vld_p1 <= issue;
    end

    ext_msg_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_vld_p1),
        .push_data (ram_data_out),
        .pop       (pop),
        .pop_data  (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_valid = ~fifo_empty;

endmodule

// File: tb/tb_ext_msg_reader.sv
// Directed testbench for ext_msg_reader with a behavioural single-port RAM.
module tb_ext_msg_reader;

    localparam int DW = 5;
    localparam int AW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] num_msgs;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_address;
    logic          ram_cs;
    logic          ram_we;
    logic [DW-1:0] ram_data_out = '0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs) ram_data_out <= mem[ram_address];
    end

    ext_msg_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .num_msgs     (num_msgs),
        .busy         (busy),
        .done         (done),
        .ram_address  (ram_address),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_data_out (ram_data_out),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_ready      (m_ready)
    );

    task automatic test_reset();
        #3;
        tests++;
        if ({busy, done, ram_cs, ram_we, m_valid, m_last} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, want 000000", {busy, done, ram_cs, ram_we, m_valid, m_last});
        end
        tests++;
        if (m_data !== '0 || ram_address !== '0) begin
            fails++;
            $display("FAIL reset_bus: m_data=%h ram_address=%h, want 0/0", m_data, ram_address);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [AW-1:0] ea;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h10; num_msgs = 9'd4; m_ready = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || ram_cs !== 1'b0) begin
            fails++;
            $display("FAIL basic_c0: busy=%b ram_cs=%b, want 0/0", busy, ram_cs);
        end
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            tests++;
            if ({busy, done, ram_cs, m_valid, m_last} !==
                {(c >= 1 && c <= 6), (c == 7), (c <= 4), (c >= 3 && c <= 6), (c == 6)}) begin
                fails++;
                $display("FAIL basic_ctrl c%0d: busy/done/cs/valid/last=%b%b%b%b%b", c, busy, done, ram_cs, m_valid, m_last);
            end
            if (c <= 4) begin
                ea = 8'h10 + 8'(c - 1);
                tests++;
                if (ram_address !== ea || ram_we !== 1'b0) begin
                    fails++;
                    $display("FAIL basic_addr c%0d: got %h we=%b, want %h we=0", c, ram_address, ram_we, ea);
                end
            end
            if (c >= 3 && c <= 6) begin
                tests++;
                if (m_data !== 5'(c - 2)) begin
                    fails++;
                    $display("FAIL basic_data c%0d: got %h, want %h", c, m_data, 5'(c - 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp [6] = '{5'h11, 5'h02, 5'h1F, 5'h00, 5'h15, 5'h0A};
        int            beats   = 0;
        int            issues  = 0;
        int            done_at = -1;
        logic          pv      = 1'b0;
        logic          pr      = 1'b0;
        logic [DW-1:0] pd      = '0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h40; num_msgs = 9'd6; m_ready = 1'b1;
        for (int c = 1; c < 80 && done_at < 0; c++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            m_ready = (c % 3 == 0);
            #1;
            if (pv && !pr) begin
                tests++;
                if (m_valid !== 1'b1 || m_data !== pd) begin
                    fails++;
                    $display("FAIL bp_stable c%0d: valid=%b data=%h, want 1/%h", c, m_valid, m_data, pd);
                end
            end
            if (ram_cs) begin
                tests++;
                if (issues >= 6 || ram_address !== 8'h40 + 8'(issues)) begin
                    fails++;
                    $display("FAIL bp_addr issue%0d: got %h, want %h", issues, ram_address, 8'h40 + 8'(issues));
                end
                issues++;
            end
            if (m_valid && m_ready) begin
                tests++;
                if (beats >= 6 || m_data !== exp[beats] || m_last !== (beats == 5)) begin
                    fails++;
                    $display("FAIL bp_beat%0d: data=%h last=%b, want %h/%b", beats, m_data, m_last, exp[beats], (beats == 5));
                end
                beats++;
            end
            tests++;
            if (issues - beats > 2) begin
                fails++;
                $display("FAIL bp_occupancy c%0d: outstanding=%0d, want <=2", c, issues - beats);
            end
            if (done) done_at = c;
            pv = m_valid; pr = m_ready; pd = m_data;
        end
        tests++;
        if (beats != 6 || issues != 6 || done_at < 0) begin
            fails++;
            $display("FAIL bp_totals: beats=%0d issues=%0d done_at=%0d, want 6/6/>=0", beats, issues, done_at);
        end
        m_ready = 1'b1;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic [DW-1:0] ed [4] = '{5'h1E, 5'h1F, 5'h05, 5'h06};
        int            beats  = 0;
        int            issues = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'hFE; num_msgs = 9'd4; m_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (ram_cs) begin
                tests++;
                if (issues >= 4 || ram_address !== ea[issues]) begin
                    fails++;
                    $display("FAIL wrap_addr issue%0d: got %h, want %h", issues, ram_address, ea[issues]);
                end
                issues++;
            end
            if (m_valid) begin
                tests++;
                if (beats >= 4 || c != 3 + beats || m_data !== ed[beats]) begin
                    fails++;
                    $display("FAIL wrap_beat%0d c%0d: data=%h, want %h at c%0d", beats, c, m_data, ed[beats], 3 + beats);
                end
                beats++;
            end
        end
        tests++;
        if (beats != 4 || issues != 4) begin
            fails++;
            $display("FAIL wrap_totals: beats=%0d issues=%0d, want 4/4", beats, issues);
        end
    endtask

    task automatic test_zero_length();
        int done_at  = -1;
        int activity = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h20; num_msgs = 9'd0; m_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (ram_cs || m_valid) activity++;
            if (done && done_at < 0) done_at = c;
        end
        tests++;
        if (activity != 0) begin
            fails++;
            $display("FAIL zero_activity: cs/valid cycles=%0d, want 0", activity);
        end
        tests++;
        if (done_at < 1 || done_at > 2) begin
            fails++;
            $display("FAIL zero_done: done at c%0d, want c1..c2", done_at);
        end
    endtask

    task automatic test_busy_and_reset();
        int beats  = 0;
        int dones  = 0;
        int issues = 0;
        // A second start at c2 must not disturb the running job
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h10; num_msgs = 9'd4; m_ready = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            start     = (c == 2);
            base_addr = (c == 2) ? 8'h40 : 8'h10;
            num_msgs  = (c == 2) ? 9'd6 : 9'd4;
            #1;
            if (ram_cs) begin
                tests++;
                if (ram_address !== 8'h10 + 8'(issues)) begin
                    fails++;
                    $display("FAIL busy_addr issue%0d: got %h, want %h", issues, ram_address, 8'h10 + 8'(issues));
                end
                issues++;
            end
            if (m_valid) begin
                tests++;
                if (beats >= 4 || m_data !== 5'(beats + 1)) begin
                    fails++;
                    $display("FAIL busy_beat%0d: data=%h, want %h", beats, m_data, 5'(beats + 1));
                end
                beats++;
            end
            if (done) dones++;
        end
        tests++;
        if (beats != 4 || issues != 4 || dones != 1) begin
            fails++;
            $display("FAIL busy_totals: beats=%0d issues=%0d dones=%0d, want 4/4/1", beats, issues, dones);
        end

        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h40; num_msgs = 9'd6;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
        end
        tests++;
        if (m_valid !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_valid: got %b, want 1", m_valid);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({busy, done, ram_cs, ram_we, m_valid, m_last} !== 6'b0 || m_data !== '0 || ram_address !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: ctrl=%b data=%h addr=%h, want 0", {busy, done, ram_cs, ram_we, m_valid, m_last}, m_data, ram_address);
        end
        @(posedge clk); #1;
        tests++;
        if ({busy, done, ram_cs, m_valid} !== 4'b0) begin
            fails++;
            $display("FAIL midreset_hold: busy/done/cs/valid=%b, want 0000", {busy, done, ram_cs, m_valid});
        end
        reset = 1'b1;

        beats = 0; dones = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h10; num_msgs = 9'd2;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (m_valid) begin
                tests++;
                if (beats >= 2 || c != 3 + beats || m_data !== 5'(beats + 1) || m_last !== (beats == 1)) begin
                    fails++;
                    $display("FAIL post_reset_beat%0d c%0d: data=%h last=%b", beats, c, m_data, m_last);
                end
                beats++;
            end
            if (done) begin
                tests++;
                if (c != 5) begin
                    fails++;
                    $display("FAIL post_reset_done: at c%0d, want c5", c);
                end
                dones++;
            end
        end
        tests++;
        if (beats != 2 || dones != 1) begin
            fails++;
            $display("FAIL post_reset_totals: beats=%0d dones=%0d, want 2/1", beats, dones);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; num_msgs = '0; m_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 5'(i * 7 + 3);
        mem[8'h10] = 5'h01; mem[8'h11] = 5'h02; mem[8'h12] = 5'h03; mem[8'h13] = 5'h04;
        mem[8'h40] = 5'h11; mem[8'h41] = 5'h02; mem[8'h42] = 5'h1F;
        mem[8'h43] = 5'h00; mem[8'h44] = 5'h15; mem[8'h45] = 5'h0A;
        mem[8'hFE] = 5'h1E; mem[8'hFF] = 5'h1F; mem[8'h00] = 5'h05; mem[8'h01] = 5'h06;

        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_busy_and_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
